// File: rtl/permutation_host.sv
// Host-side responder for the permutation core: buffers one block, feeds the
// core word by word, captures results in place and streams the block back out.
module permutation_host #(
  parameter int WIDTH = 25,
  parameter int WORDS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  output logic             permStart,
  input  logic             permReady,
  input  logic             permPutInput,
  output logic [WIDTH-1:0] permData,
  input  logic             permOutReady,
  input  logic [WIDTH-1:0] permResult,
  output logic             outValid,
  input  logic             outAccept,
  output logic [WIDTH-1:0] outData,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int PTR_W = $clog2(WORDS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(WORDS - 1);

  typedef enum logic [1:0] {FILL, LAUNCH, SERVE, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] drPtr_q, drPtr_d;
  logic             firstServe_q, firstServe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] mem_q [WORDS];
  logic             memWe;
  logic [PTR_W-1:0] memAddr;
  logic [WIDTH-1:0] memWdata;

  always_comb begin
    state_d      = state_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    drPtr_d      = drPtr_q;
    firstServe_d = 1'b0;
    done_d       = 1'b0;
    error_d      = error_q;
    memWe        = 1'b0;
    memAddr      = wrPtr_q;
    memWdata     = inData;
    inReady      = 1'b0;
    permStart    = 1'b0;
    outValid     = 1'b0;

    // Core strobes only make sense while a block is being served.
    if (state_q != SERVE && (permPutInput || permOutReady)) begin
      error_d = 1'b1;
    end

    case (state_q)
      FILL: begin
        inReady = 1'b1;
        if (inValid) begin
          memWe    = 1'b1;
          memAddr  = wrPtr_q;
          memWdata = inData;
          wrPtr_d  = wrPtr_q + 1'b1;
          if (wrPtr_q == LAST) state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        permStart = permReady;
        if (permReady) begin
          state_d      = SERVE;
          firstServe_d = 1'b1;
        end
      end
      SERVE: begin
        // The core may still look idle on the cycle right after start; any later
        // idle means it abandoned the block, so drain what we have.
        if (permReady && !firstServe_q) begin
          error_d = 1'b1;
          state_d = DRAIN;
          rdPtr_d = '0;
        end else if (permOutReady) begin
          memWe    = 1'b1;
          memAddr  = rdPtr_q;
          memWdata = permResult;
          rdPtr_d  = rdPtr_q + 1'b1;
          if (rdPtr_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        outValid = 1'b1;
        if (outAccept) begin
          drPtr_d = drPtr_q + 1'b1;
          if (drPtr_q == LAST) begin
            state_d = FILL;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      drPtr_q      <= '0;
      firstServe_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      drPtr_q      <= drPtr_d;
      firstServe_q <= firstServe_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem_q[memAddr] <= memWdata;
  end

  assign permData = mem_q[rdPtr_q];
  assign outData  = mem_q[drPtr_q];
  assign busy     = (state_q != FILL);
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: doc/permutation_host.md
# permutation_host

Host-side responder for the permutation datapath controller. Buffers a block of `WORDS` input words from an upstream valid/ready stream and launches the permutation. It answers each per-iteration input request with the next buffered word and captures each per-iteration result in place. Once all results are collected, it streams the block back out through a downstream valid/ready port. It sits between the system bus adapter and the permutation core, driving the core's `start`/`putInput`/`outReady` handshake from the opposite end.

## Interface
- `WIDTH`, default 25: word width of input, result and stream data.
- `WORDS`, default 64: words per block. Must be a power of two and ≥2. Equals the core's iteration count (core `cntCo` terminal).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `inValid` in 1: upstream word valid.
- `inReady` out 1: block accepts upstream word.
- `inData` in WIDTH: upstream word.
- `permStart` out 1: start pulse to core.
- `permReady` in 1: core idle.
- `permPutInput` in 1: core requests next input word.
- `permData` out WIDTH: input word presented to core.
- `permOutReady` in 1: core result valid this cycle.
- `permResult` in WIDTH: core result word.
- `outValid` out 1: downstream word valid.
- `outAccept` in 1: downstream accepts word.
- `outData` out WIDTH: downstream word.
- `busy` out 1: high in every state except FILL.
- `done` out 1: one-cycle pulse after the last drained word.
- `error` out 1: sticky protocol-error flag, cleared only by `rst`.

## Operation
- Storage: single buffer `buf[0..WORDS-1]` of WIDTH bits, not reset.
- Pointers: `wrPtr`, `rdPtr`, `drPtr`, each `clog2(WORDS)` bits. Each wraps from WORDS-1 to 0 on its final transfer.
- FILL
  - `inReady`=1.
  - On `inValid&inReady`: `buf[wrPtr]<=inData`, `wrPtr++`.
  - Acceptance at `wrPtr==WORDS-1` → LAUNCH.
- LAUNCH
  - `permStart = permReady` (combinational, this state only).
  - When `permReady`=1: → SERVE.
  - Otherwise hold in LAUNCH.
- SERVE
  - `permData = buf[rdPtr]`, stable from entry until `rdPtr` advances. This covers the core's request and load cycles.
  - `permPutInput` is a request strobe only; no state change.
  - On `permOutReady`: `buf[rdPtr]<=permResult`, `rdPtr++`.
  - Result at `rdPtr==WORDS-1` → DRAIN.
- DRAIN
  - `outValid`=1, `outData=buf[drPtr]`.
  - On `outValid&outAccept`: `drPtr++`.
  - Acceptance at `drPtr==WORDS-1` → FILL, `done`=1 next cycle.
- Error conditions set `error` and are otherwise ignored (no buffer write, no pointer move):
  - `permPutInput` or `permOutReady` in FILL, LAUNCH or DRAIN.
  - `permReady` high in SERVE later than the first SERVE cycle, with `rdPtr` not yet wrapped (core returned to idle early).
- Early core idle in SERVE also forces → DRAIN. The drained block contains results for indices `<rdPtr` and original inputs for the rest.
- No overlap of blocks: FILL is never entered while DRAIN has words outstanding.

## Timing
- Reset values:
  - state FILL, all pointers 0.
  - `inReady`=1, `busy`=0.
  - `permStart`=0, `outValid`=0, `done`=0, `error`=0.
  - `permData`/`outData` = `buf[0]` (contents undefined).
- `permStart` is high exactly one cycle per block: the first LAUNCH cycle with `permReady`=1.
- Core cadence per word is request, load, write, inform (4 cycles), plus 1 init cycle.
- Block latency with no stalls:
  - WORDS cycles fill
  - 1 launch
  - 1+4·WORDS serve
  - WORDS drain
  - i.e. 6·WORDS+2 cycles from first `inValid` to `done`.
- Backpressure:
  - FILL holds indefinitely while `inValid`=0.
  - DRAIN holds `outData` stable while `outAccept`=0.
- Simultaneous events:
  - `permOutReady` on the last word moves to DRAIN at the same edge; `outValid` rises the next cycle.
  - Last DRAIN accept: `inReady` rises the next cycle, same cycle as `done`.
- Reset mid-block:
  - Returns to FILL immediately; the partial block is discarded.
  - `error` clears.
  - The core is reset by the same `rst`.

## Test plan
- Reset: assert `rst` mid-SERVE → next cycle `inReady`=1, `busy`=0, `error`=0, `permStart`=0; a fresh 4-word block then completes normally.
- Nominal (WORDS=4, WIDTH=25), core model returning input XOR 25'h1ABCDEF:
  - fill 0,1,2,3 → one `permStart` pulse.
  - `permData` reads 0,1,2,3 during successive requests.
  - drained words are 0x1ABCDEF,0x1ABCDEE,0x1ABCDED,0x1ABCDEC.
  - `done` asserts 26 cycles after first `inValid`.
- Launch stall: hold `permReady`=0 for 5 cycles after fill → `permStart` stays low, then pulses exactly once when `permReady` rises.
- Backpressure:
  - random `inValid`/`outAccept` gaps → no word lost or duplicated.
  - `outData` is held while `outAccept`=0.
- Protocol errors, each with no buffer change:
  - `permOutReady` pulsed in FILL → `error`=1.
  - `permReady` high after 2 of 4 results → `error`=1, DRAIN yields 2 results then 2 original inputs.
- Back-to-back blocks: second block filled right after `done` → pointers wrapped to 0, second results correct, `permStart` pulses once per block.
